// File: rtl/minhash_pkg.sv
// Shared types, sizes and hash helper for the MinHash similarity datapath.
//   K_NUM / K_W  : k-mers per sequence and k-mer / hash width
//   ACC_W        : width of the match accumulator, saturating at ACC_MAX
//   hash_ax_b    : universal hash (a*x + b) mod 2^K_W
package minhash_pkg;

   localparam int unsigned K_NUM   = 49;
   localparam int unsigned K_W     = 32;
   localparam int unsigned ACC_W   = 5;
   localparam int unsigned ACC_MAX = 31;

   typedef logic [K_W-1:0]            kmer_t;
   typedef logic [K_NUM-1:0][K_W-1:0] kmer_set_t;
   typedef logic [ACC_W-1:0]          acc_t;

   // All operands are K_W bits, so the product and sum wrap modulo 2^K_W.
   function automatic kmer_t hash_ax_b(input kmer_t a, input kmer_t b, input kmer_t x);
      return a * x + b;
   endfunction

endpackage

// File: rtl/minhash_unit.sv
// Combinational minhash of one k-mer set: hashes every k-mer with (a, b)
// and reduces the results through a balanced min tree.
//   kmers    in   K_NUM packed k-mers
//   a, b     in   hash coefficients
//   min_hash out  unsigned minimum hash over the set (combinational)
module minhash_unit
   import minhash_pkg::*;
(
   input  kmer_set_t kmers,
   input  kmer_t     a,
   input  kmer_t     b,
   output kmer_t     min_hash
);

   localparam int unsigned LEAVES = 64;

   // Heap-ordered tree: node[1] is the root, leaves sit at LEAVES..2*LEAVES-1.
   kmer_t node [2*LEAVES-1:1];

   always_comb begin
      for (int i = 1; i < int'(2*LEAVES); i++) begin
         node[i] = '1;
      end
      for (int i = 0; i < int'(K_NUM); i++) begin
         node[int'(LEAVES) + i] = hash_ax_b(a, b, kmers[i]);
      end
      // Unused leaves stay all-ones so they never win the minimum.
      for (int i = int'(LEAVES) - 1; i >= 1; i--) begin
         node[i] = (node[2*i+1] < node[2*i]) ? node[2*i+1] : node[2*i];
      end
   end

   assign min_hash = node[1];

endmodule

// File: rtl/top_desgin_module.sv
// MinHash Jaccard-similarity estimator: one hash round per non-reset cycle,
// counts rounds whose per-sequence minima agree (saturating).
//   clk               in   rising-edge clock
//   rstN              in   synchronous reset, active-high
//   randA, randB      in   hash coefficients for the current round
//   kmersSeqOne/Two   in   packed k-mer sets of the two sequences
//   jaccardSimilarity out  registered count of matching rounds
module top_desgin_module
   import minhash_pkg::*;
(
   input  logic             clk,
   input  logic             rstN,
   input  logic [K_W-1:0]   randA,
   input  logic [K_W-1:0]   randB,
   input  kmer_set_t        kmersSeqOne,
   input  kmer_set_t        kmersSeqTwo,
   output logic [ACC_W-1:0] jaccardSimilarity
);

   kmer_t min_one_c;
   kmer_t min_two_c;
   kmer_t min_one_q;
   kmer_t min_two_q;
   logic  valid1_q;
   acc_t  acc_q;

   minhash_unit u_min_one (
      .kmers    (kmersSeqOne),
      .a        (randA),
      .b        (randB),
      .min_hash (min_one_c)
   );

   minhash_unit u_min_two (
      .kmers    (kmersSeqTwo),
      .a        (randA),
      .b        (randB),
      .min_hash (min_two_c)
   );

   // Stage 1 captures the minima; stage 2 compares last cycle's minima.
   always_ff @(posedge clk) begin
      if (rstN) begin
         min_one_q <= '0;
         min_two_q <= '0;
         valid1_q  <= 1'b0;
         acc_q     <= '0;
      end else begin
         min_one_q <= min_one_c;
         min_two_q <= min_two_c;
         valid1_q  <= 1'b1;
         if (valid1_q && (min_one_q == min_two_q) && (acc_q != ACC_W'(ACC_MAX))) begin
            acc_q <= acc_q + ACC_W'(1);
         end
      end
   end

   assign jaccardSimilarity = acc_q;

endmodule

// File: tb/tb_top_desgin_module.sv
// Scoreboard bench for top_desgin_module: the driver pushes the expected
// count for every edge, a monitor pops and compares after each edge.
module tb_top_desgin_module;
   import minhash_pkg::*;

   logic       clk = 1'b0;
   logic       rstN;
   kmer_t      randA;
   kmer_t      randB;
   kmer_set_t  seq_one;
   kmer_set_t  seq_two;
   logic [4:0] jac;

   always #5 clk = ~clk;

   top_desgin_module dut (
      .clk               (clk),
      .rstN              (rstN),
      .randA             (randA),
      .randB             (randB),
      .kmersSeqOne       (seq_one),
      .kmersSeqTwo       (seq_two),
      .jaccardSimilarity (jac)
   );

   logic [4:0] exp_q [$];
   string      name_q [$];
   int         checks = 0;
   int         errors = 0;

   // Reference pipeline state.
   kmer_t m_min1, m_min2;
   logic  m_valid;
   int    m_acc;

   function automatic kmer_t ref_min(input kmer_set_t s, input kmer_t a, input kmer_t b);
      kmer_t       best;
      kmer_t       h;
      logic [63:0] p;
      best = 32'hFFFF_FFFF;
      for (int i = 0; i < 49; i++) begin
         p = {32'd0, a} * {32'd0, s[i]};
         h = p[31:0] + b;
         if (h < best) best = h;
      end
      return best;
   endfunction

   // Drive one edge; hand >= 0 gives a hand-computed expectation, else the model's.
   task automatic step(input logic rst, input kmer_t a, input kmer_t b,
                       input string nm, input int hand);
      rstN  = rst;
      randA = a;
      randB = b;
      if (rst) begin
         m_acc = 0; m_min1 = '0; m_min2 = '0; m_valid = 1'b0;
      end else begin
         if (m_valid && (m_min1 == m_min2) && (m_acc < 31)) m_acc++;
         m_min1  = ref_min(seq_one, a, b);
         m_min2  = ref_min(seq_two, a, b);
         m_valid = 1'b1;
      end
      exp_q.push_back((hand >= 0) ? 5'(hand) : 5'(m_acc));
      name_q.push_back(nm);
      @(posedge clk);
      #2;
   endtask

   task automatic rounds(input int n, input string nm);
      for (int i = 0; i < n; i++) begin
         step(1'b0, 32'h9E37_79B1 ^ 32'(i * 7919), 32'(i) * 32'h0001_0001, nm, -1);
      end
   endtask

   task automatic set_ident();
      for (int i = 0; i < 49; i++) begin
         seq_one[i] = 32'(i) * 32'h0101_0101;
      end
      seq_two = seq_one;
   endtask

   task automatic set_const(input kmer_t v1, input kmer_t v2);
      for (int i = 0; i < 49; i++) begin
         seq_one[i] = v1;
         seq_two[i] = v2;
      end
   endtask

   // Monitor: one comparison per edge that has a pending expectation.
   initial begin
      logic [4:0] e;
      string      n;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checks++;
            if (jac !== e) begin
               errors++;
               $display("FAIL %s: got %0d expected %0d at %0t", n, jac, e, $time);
            end
         end
      end
   end

   initial begin
      set_ident();
      step(1'b1, 32'd0, 32'd0, "reset", 0);
      step(1'b1, 32'd0, 32'd0, "reset", 0);

      // Identical sets: 8 rounds, extra edge counts the 8th.
      rounds(8, "ident");
      step(1'b0, 32'd1, 32'd2, "ident_final", 8);
      step(1'b1, 32'd0, 32'd0, "ident_reset", 0);

      // Disjoint sets: minima 0 vs 1 every round.
      set_const(32'd0, 32'd1);
      for (int i = 0; i < 9; i++) step(1'b0, 32'd1, 32'd0, "disjoint", 0);
      step(1'b1, 32'd0, 32'd0, "disjoint_reset", 0);

      // 2*(-1) = 0xFFFFFFFE but (-2)*(-1) wraps to 2: minima differ.
      set_const(32'd2, 32'hFFFF_FFFE);
      step(1'b0, 32'hFFFF_FFFF, 32'd0, "wrap_neg", 0);
      step(1'b0, 32'hFFFF_FFFF, 32'd0, "wrap_neg_final", 0);
      step(1'b1, 32'd0, 32'd0, "wrap_neg_reset", 0);

      // 2*2^31 and 4*2^31 both wrap to 0, plus 5: equal minima.
      set_const(32'd2, 32'd4);
      step(1'b0, 32'h8000_0000, 32'd5, "wrap_prod", 0);
      step(1'b0, 32'h8000_0000, 32'd5, "wrap_prod_final", 1);
      step(1'b1, 32'd0, 32'd0, "wrap_prod_reset", 0);

      // Offset addition wraps past 2^32 on both sides identically.
      set_const(32'd3, 32'd3);
      step(1'b0, 32'd1, 32'hFFFF_FFFF, "wrap_add", 0);
      step(1'b0, 32'd1, 32'hFFFF_FFFF, "wrap_add_final", 1);
      step(1'b1, 32'd0, 32'd0, "wrap_add_reset", 0);

      // Latency: round at edge 1 shows up only after edge 2.
      set_ident();
      step(1'b0, 32'd7, 32'd9, "latency_e1", 0);
      step(1'b0, 32'd7, 32'd9, "latency_e2", 1);
      step(1'b1, 32'd0, 32'd0, "latency_reset", 0);

      // Saturation: 40 rounds + extra edge; 31 reached after edge 32.
      for (int i = 1; i <= 41; i++) begin
         step(1'b0, 32'(i) * 32'h0102_0305, 32'(i), "saturate",
              (i == 32 || i == 41) ? 31 : -1);
      end
      step(1'b1, 32'd0, 32'd0, "saturate_reset", 0);

      // Reset mid-run discards progress, then counting restarts.
      for (int i = 1; i <= 5; i++) step(1'b0, 32'(i) + 32'd11, 32'd3, "midrun", (i == 5) ? 4 : -1);
      step(1'b1, 32'd0, 32'd0, "midrun_reset", 0);
      rounds(3, "midrun_restart");
      step(1'b0, 32'd5, 32'd6, "midrun_final", 3);
      step(1'b1, 32'd0, 32'd0, "mixed_reset", 0);

      // Partial overlap: result depends on coefficients, model-checked.
      set_ident();
      for (int i = 0; i < 49; i += 2) seq_two[i] = 32'hA5A5_0000 + 32'(i * 977);
      rounds(12, "mixed");
      step(1'b0, 32'h1234_5679, 32'h0BAD_F00D, "mixed_final", -1);

      repeat (3) @(posedge clk);
      #3;
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d pending expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
